// File: rtl/nclic_sched.sv
// nCLIC interrupt scheduler: per-source pending/enable/priority, max-priority
// arbitration, req/ack handshake to the core and a nested level stack.

module nclic_prio_tree #(
  parameter int  TreeVal = 8,
  parameter int  TreeIdx = 3,
  parameter bit  MaxMode = 1'b1,
  localparam int N       = 2 ** TreeIdx
) (
  input  logic [N*TreeVal-1:0] vals,
  output logic [TreeVal-1:0]   best_val,
  output logic [TreeIdx-1:0]   best_idx
);
  logic [TreeVal-1:0] nv [2*N-1];
  logic [TreeIdx-1:0] ni [2*N-1];
  logic               pick_r;

  // heap layout: node k has children 2k+1 (lower ids) and 2k+2 (higher ids)
  always_comb begin
    pick_r = 1'b0;
    for (int i = 0; i < N; i++) begin
      nv[N-1+i] = vals[i*TreeVal +: TreeVal];
      ni[N-1+i] = TreeIdx'(i);
    end
    for (int k = N-2; k >= 0; k--) begin
      pick_r = MaxMode ? (nv[2*k+2] >= nv[2*k+1])
                       : (nv[2*k+2] <= nv[2*k+1]);
      nv[k]  = pick_r ? nv[2*k+2] : nv[2*k+1];
      ni[k]  = pick_r ? ni[2*k+2] : ni[2*k+1];
    end
  end

  assign best_val = nv[0];
  assign best_idx = ni[0];
endmodule

module nclic_sched #(
  parameter int  NumSrc    = 8,
  parameter int  PrioWidth = 8,
  parameter int  NestDepth = 4,
  localparam int IdW       = $clog2(NumSrc),
  localparam int DW        = $clog2(NestDepth+1),
  localparam int SW        = $clog2(NestDepth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NumSrc-1:0]    irq_i,
  input  logic                 cfg_we,
  input  logic [IdW-1:0]       cfg_idx,
  input  logic                 cfg_en,
  input  logic [PrioWidth-1:0] cfg_prio,
  output logic                 irq_req_o,
  output logic [IdW-1:0]       irq_id_o,
  output logic [PrioWidth-1:0] irq_prio_o,
  input  logic                 irq_ack_i,
  input  logic                 irq_done_i,
  output logic [PrioWidth-1:0] level_o,
  output logic [DW-1:0]        depth_o,
  output logic                 err_o
);
  localparam logic [DW-1:0] Full = DW'(NestDepth);
  localparam logic [DW-1:0] One  = DW'(1);

  logic [NumSrc-1:0]           pend;
  logic [NumSrc-1:0]           en;
  logic [NumSrc-1:0]           clr;
  logic [PrioWidth-1:0]        prio [NumSrc];
  logic [PrioWidth-1:0]        stk  [NestDepth];
  logic [NumSrc*PrioWidth-1:0] cand;
  logic [PrioWidth-1:0]        best_val;
  logic [IdW-1:0]              best_idx;
  logic [DW-1:0]               dm1;
  logic                        ack;
  logic                        pop;
  logic                        win;
  logic                        bad;

  always_comb begin
    cand = '0;
    for (int i = 0; i < NumSrc; i++) begin
      cand[i*PrioWidth +: PrioWidth] =
        (pend[i] && en[i]) ? prio[i] : '0;
    end
  end

  nclic_prio_tree #(
    .TreeVal (PrioWidth),
    .TreeIdx (IdW),
    .MaxMode (1'b1)
  ) u_tree (
    .vals     (cand),
    .best_val (best_val),
    .best_idx (best_idx)
  );

  assign ack = irq_ack_i && irq_req_o;
  assign pop = irq_done_i && (depth_o != '0);
  assign bad = (irq_done_i && (depth_o == '0))
            || (irq_ack_i && !irq_req_o);
  assign win = (best_val > level_o) && (depth_o < Full);
  assign dm1 = depth_o - One;
  assign clr = ack ? (NumSrc'(1) << irq_id_o) : '0;

  // a fresh pulse beats the ack clear of the same source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      en   <= '0;
      for (int i = 0; i < NumSrc; i++) prio[i] <= '0;
    end else begin
      pend <= (pend & ~clr) | irq_i;
      if (cfg_we) begin
        en[cfg_idx]   <= cfg_en;
        prio[cfg_idx] <= cfg_prio;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_req_o  <= 1'b0;
      irq_id_o   <= '0;
      irq_prio_o <= '0;
    end else begin
      irq_req_o <= win && !ack;
      if (win) begin
        irq_id_o   <= best_idx;
        irq_prio_o <= best_val;
      end
    end
  end

  // ack+done swaps the level in place: pop then push leaves the stack as is
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_o <= '0;
      depth_o <= '0;
      err_o   <= 1'b0;
      for (int j = 0; j < NestDepth; j++) stk[j] <= '0;
    end else begin
      if (ack && pop) begin
        level_o <= irq_prio_o;
      end else if (ack) begin
        stk[depth_o[SW-1:0]] <= level_o;
        depth_o              <= depth_o + One;
        level_o              <= irq_prio_o;
      end else if (pop) begin
        level_o <= stk[dm1[SW-1:0]];
        depth_o <= dm1;
      end
      if (bad) err_o <= 1'b1;
    end
  end
endmodule
